// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Optional stall statistics are enabled with PIPE_CTRL_STATS_EN.
package pipe_ctrl_pkg;

    localparam int STBITS           = 3;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int RNBITS_DEF       = 5;
    localparam int CNTBITS_DEF      = 32;

    typedef enum logic [STBITS-1:0] {
        ST_IDLE  = 3'b000,
        ST_RUN   = 3'b001,
        ST_STEP  = 3'b010,
        ST_DRAIN = 3'b011,
        ST_DONE  = 3'b100
    } state_e;

    function automatic logic is_active(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Debug, hazard and pipeline-register control bundle of pipeline_ctrl.
// The controller uses the slave modport; the core/debug side uses master.
interface pipeline_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int RNBITS  = RNBITS_DEF,
    parameter int CNTBITS = CNTBITS_DEF
);

    logic               i_dbg_run;
    logic               i_dbg_step;
    logic               i_dbg_stop;
    logic               i_ID_EX_MemRead;
    logic [RNBITS-1:0]  i_ID_EX_Rt;
    logic [RNBITS-1:0]  i_IF_ID_Rs;
    logic [RNBITS-1:0]  i_IF_ID_Rt;
    logic               i_branch_taken;
    logic               i_halt_id;
    logic               o_pc_en;
    logic               o_IF_ID_en;
    logic               o_IF_ID_flush;
    logic               o_ID_EX_bubble;
    logic               o_pipe_en;
    logic [STBITS-1:0]  o_state;
    logic               o_done;
    logic [CNTBITS-1:0] o_cycle_cnt;
    logic [CNTBITS-1:0] o_stall_cnt;

    modport master (
        output i_dbg_run, i_dbg_step, i_dbg_stop,
        output i_ID_EX_MemRead, i_ID_EX_Rt,
        output i_IF_ID_Rs, i_IF_ID_Rt,
        output i_branch_taken, i_halt_id,
        input  o_pc_en, o_IF_ID_en, o_IF_ID_flush,
        input  o_ID_EX_bubble, o_pipe_en, o_state,
        input  o_done, o_cycle_cnt, o_stall_cnt
    );

    modport slave (
        input  i_dbg_run, i_dbg_step, i_dbg_stop,
        input  i_ID_EX_MemRead, i_ID_EX_Rt,
        input  i_IF_ID_Rs, i_IF_ID_Rt,
        input  i_branch_taken, i_halt_id,
        output o_pc_en, o_IF_ID_en, o_IF_ID_flush,
        output o_ID_EX_bubble, o_pipe_en, o_state,
        output o_done, o_cycle_cnt, o_stall_cnt
    );

endinterface

// File: rtl/id_hazard_detect.sv
// Load-use comparator: load in EX whose destination feeds the ID instruction.
module id_hazard_detect #(
    parameter int RNBITS = 5
) (
    input  logic              mem_read_i,
    input  logic [RNBITS-1:0] ex_rt_i,
    input  logic [RNBITS-1:0] id_rs_i,
    input  logic [RNBITS-1:0] id_rt_i,
    output logic              load_use_o
);

    assign load_use_o = mem_read_i
                     && (ex_rt_i != '0)
                     && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Execution-mode FSM plus stall/flush strobe generation for the 5-stage core.
// Define PIPE_CTRL_STATS_EN to build the saturating load-use stall counter.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RNBITS       = RNBITS_DEF,
    parameter int CNTBITS      = CNTBITS_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    pipeline_ctrl_if.slave bus
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [DCW-1:0]     drain_q, drain_d;
    logic [CNTBITS-1:0] cycle_q;
    logic               load_use;
    logic               active;
    logic               halt_go;
    logic               pc_en, ifid_en, flush, bubble, pipe_en;

    id_hazard_detect #(.RNBITS(RNBITS)) u_hazard (
        .mem_read_i (bus.i_ID_EX_MemRead),
        .ex_rt_i    (bus.i_ID_EX_Rt),
        .id_rs_i    (bus.i_IF_ID_Rs),
        .id_rt_i    (bus.i_IF_ID_Rt),
        .load_use_o (load_use)
    );

    assign active  = is_active(state_q);
    // A stalled HALT is not yet committed; it is seen again next active cycle.
    assign halt_go = bus.i_halt_id && !load_use;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        flush   = 1'b0;
        bubble  = 1'b0;
        pipe_en = 1'b0;
        if (active) begin
            pipe_en = 1'b1;
            if (load_use) begin
                bubble = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                flush   = bus.i_branch_taken;
            end
        end
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_dbg_run)       state_d = ST_RUN;
                else if (bus.i_dbg_step) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (halt_go) begin
                    state_d = ST_DRAIN;
                    drain_d = DCW'(DRAIN_CYCLES - 1);
                end else if (bus.i_dbg_stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (halt_go) begin
                    state_d = ST_DRAIN;
                    drain_d = DCW'(DRAIN_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                pipe_en = 1'b1;
                bubble  = 1'b1;
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - DCW'(1);
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (pipe_en && !(&cycle_q)) cycle_q <= cycle_q + CNTBITS'(1);
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [CNTBITS-1:0] stall_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_q <= '0;
        end else if (active && load_use && !(&stall_q)) begin
            stall_q <= stall_q + CNTBITS'(1);
        end
    end

    assign bus.o_stall_cnt = stall_q;
`else
    assign bus.o_stall_cnt = '0;
`endif

    assign bus.o_pc_en        = pc_en;
    assign bus.o_IF_ID_en     = ifid_en;
    assign bus.o_IF_ID_flush  = flush;
    assign bus.o_ID_EX_bubble = bubble;
    assign bus.o_pipe_en      = pipe_en;
    assign bus.o_state        = state_q;
    assign bus.o_done         = (state_q == ST_DONE);
    assign bus.o_cycle_cnt    = cycle_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + randomized bench for pipeline_ctrl against a cycle-level mode model.
// Stall-count expectations follow PIPE_CTRL_STATS_EN.
module tb_pipeline_ctrl;

    localparam int RNB = 5;
    localparam int CNB = 32;
    localparam int DRAIN_CYCLES = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_DRAIN = 3;
    localparam int M_DONE  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pipeline_ctrl_if #(.RNBITS(RNB), .CNTBITS(CNB)) bus ();

    pipeline_ctrl #(
        .RNBITS(RNB), .CNTBITS(CNB), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int          m_mode;
    int          m_left;
    int unsigned m_cyc;
    int unsigned m_stall;
    logic        m_run, m_step, m_stop, m_mr, m_br, m_halt;
    int          m_exrt, m_rs, m_rt;
    int          pipe_seen;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_lu();
        return m_mr && (m_exrt != 0) && (m_exrt == m_rs || m_exrt == m_rt);
    endfunction

    task automatic check_all();
        bit act, lu, drn;
        act = (m_mode == M_RUN) || (m_mode == M_STEP);
        drn = (m_mode == M_DRAIN);
        lu  = m_lu();
        chk("state",  32'(bus.o_state), m_mode);
        chk("pc_en",  bus.o_pc_en, act && !lu);
        chk("ifid_en", bus.o_IF_ID_en, act && !lu);
        chk("flush",  bus.o_IF_ID_flush, act && !lu && m_br);
        chk("bubble", bus.o_ID_EX_bubble, (act && lu) || drn);
        chk("pipe_en", bus.o_pipe_en, act || drn);
        chk("done",   bus.o_done, m_mode == M_DONE);
        chk("cycles", bus.o_cycle_cnt, m_cyc);
`ifdef PIPE_CTRL_STATS_EN
        chk("stalls", bus.o_stall_cnt, m_stall);
`else
        chk("stalls", bus.o_stall_cnt, 0);
`endif
    endtask

    task automatic model_tick();
        bit act, lu;
        act = (m_mode == M_RUN) || (m_mode == M_STEP);
        lu  = m_lu();
        if (act || m_mode == M_DRAIN) m_cyc++;
        if (act && lu) m_stall++;
        case (m_mode)
            M_IDLE: begin
                if (m_run) m_mode = M_RUN;
                else if (m_step) m_mode = M_STEP;
            end
            M_RUN: begin
                if (m_halt && !lu) begin
                    m_mode = M_DRAIN;
                    m_left = DRAIN_CYCLES;
                end else if (m_stop) m_mode = M_IDLE;
            end
            M_STEP: begin
                if (m_halt && !lu) begin
                    m_mode = M_DRAIN;
                    m_left = DRAIN_CYCLES;
                end else m_mode = M_IDLE;
            end
            M_DRAIN: begin
                m_left--;
                if (m_left == 0) m_mode = M_DONE;
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic run, step, stop, mr,
                         input int exrt, rs, rt,
                         input logic br, halt);
        m_run = run; m_step = step; m_stop = stop; m_mr = mr;
        m_exrt = exrt; m_rs = rs; m_rt = rt; m_br = br; m_halt = halt;
        bus.i_dbg_run = run;
        bus.i_dbg_step = step;
        bus.i_dbg_stop = stop;
        bus.i_ID_EX_MemRead = mr;
        bus.i_ID_EX_Rt = RNB'(exrt);
        bus.i_IF_ID_Rs = RNB'(rs);
        bus.i_IF_ID_Rt = RNB'(rt);
        bus.i_branch_taken = br;
        bus.i_halt_id = halt;
    endtask

    task automatic apply(input logic run, step, stop, mr,
                         input int exrt, rs, rt,
                         input logic br, halt);
        drive(run, step, stop, mr, exrt, rs, rt, br, halt);
        #3;
        check_all();
        if (bus.o_pipe_en === 1'b1) pipe_seen++;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        m_mode = M_IDLE; m_left = 0; m_cyc = 0; m_stall = 0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pipe_seen = 0;
        do_reset();

        // Run pulse then ten hazard-free cycles
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) idle();
        chk("cyc10", bus.o_cycle_cnt, 10);

        // Load-use stall, then Rt=0 (no stall)
        apply(0, 0, 0, 1, 5, 5, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 7, 1, 7, 0, 0);

        // Load-use beats branch flush; branch alone flushes
        apply(0, 0, 0, 1, 3, 3, 0, 1, 0);
        apply(0, 0, 0, 0, 3, 3, 0, 1, 0);

        // Load-use masks HALT; halt+stop then handled next
        apply(0, 0, 0, 1, 4, 0, 4, 0, 1);
        apply(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle();

        // Three spaced single steps
        pipe_seen = 0;
        repeat (3) begin
            apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
            chk("step_st", 32'(bus.o_state), 2);
            idle();
            chk("step_idle", 32'(bus.o_state), 0);
            idle();
        end
        chk("step_cnt", pipe_seen, 3);

        // Run and step together: run wins
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("run_wins", 32'(bus.o_state), 1);
        apply(0, 0, 1, 0, 0, 0, 0, 0, 0);

        // HALT drain sequence, DONE is sticky
        do_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        apply(0, 0, 1, 0, 0, 0, 0, 0, 1);
        repeat (DRAIN_CYCLES) idle();
        chk("done_st", 32'(bus.o_state), 4);
        chk("done_o", bus.o_done, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("done_sticky", bus.o_done, 1);

        // Async reset in the middle of DRAIN
        do_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        rst_n = 1'b0;
        #2;
        chk("ar_state", 32'(bus.o_state), 0);
        chk("ar_cyc", bus.o_cycle_cnt, 0);
        chk("ar_stall", bus.o_stall_cnt, 0);
        chk("ar_done", bus.o_done, 0);
        chk("ar_pipe", bus.o_pipe_en, 0);
        chk("ar_bubble", bus.o_ID_EX_bubble, 0);
        chk("ar_pc", bus.o_pc_en, 0);
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (m_mode == M_DONE) do_reset();
            apply($urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
